aes_ark_stage: RTL
==================

// Module: aes_ark_stage
// PURPOSE
//   Parametrised AddRoundKey register stage for the iterative AES datapath.
//   Loads the initial state as text_in^w_i, then on each round result from
//   SubBytes/ShiftRows/MixColumns registers sa_i^w_i. Counts rounds and flags
//   completion; the key schedule feeds w_i and the round logic closes the loop.
// PARAMETERS
//   NBYTES  16  state width in bytes; datapath width W = 8*NBYTES
//   NR      10  number of round-key additions after the initial load (10/12/14)
//   RW      derived localparam = $clog2(NR+1); width of round_o
// PORTS
//   clk        in   1    clock, all state updates on rising edge
//   rst        in   1    asynchronous, active-high reset
//   ld_i       in   1    start a block: capture text_in^w_i
//   rnd_vld_i  in   1    round result valid on sa_i: capture sa_i^w_i
//   text_in    in   W    plaintext block
//   w_i        in   W    current round key
//   sa_i       in   W    state returned from the round logic
//   sa_o       out  W    registered AddRoundKey result
//   round_o    out  RW   round count of the value on sa_o (0 = initial load)
//   busy_o     out  1    block in progress
//   done_o     out  1    one-cycle pulse: sa_o holds the final ciphertext
//   ready_o    out  1    stage accepts ld_i/rnd_vld_i this cycle
// BEHAVIOUR
//   Reset (async, any time): sa_o=0, round_o=0, busy_o=0, done_o=0, ready_o=1,
//     FSM=IDLE. A reset mid-block aborts it; no done_o pulse follows.
//   An event is accepted only when ready_o=1; otherwise it is ignored.
//   XOR is bytewise and carry-free; no width growth. Latency is 1 cycle from
//     the accepted event to sa_o (2 cycles with precharge, see CONFIGURATION).
//   FSM IDLE: ld_i -> sa_o<=text_in^w_i, round_o<=0, busy_o<=1, go RUN.
//     rnd_vld_i is ignored in IDLE.
//   FSM RUN: rnd_vld_i -> sa_o<=sa_i^w_i, round_o<=round_o+1. If the new
//     round_o==NR, done_o=1 in that same cycle, busy_o<=0, go IDLE. sa_o and
//     round_o then hold until the next ld_i.
//   ld_i in RUN restarts the block as from IDLE, and round_o returns to 0.
//   ld_i and rnd_vld_i together: ld_i wins, and rnd_vld_i is dropped.
//   No event: sa_o, round_o and busy_o hold. done_o is high for exactly one cycle.
//   round_o never exceeds NR; no wrap-around is possible.
// CONFIGURATION
//   ARK_PRECHARGE_EN (defined): WDDL-style precharge. An accepted event enters
//     state PRE for 1 cycle: the operand XOR is latched internally, sa_o is
//     driven to all-zero and ready_o=0. The next cycle sa_o<=result and the
//     FSM goes to RUN or IDLE per the rules above; done_o is asserted on the
//     result cycle. rst during PRE discards the latched operand. Events
//     presented while ready_o=0 are ignored.
//   ARK_PRECHARGE_EN (undefined): no PRE state, ready_o is constantly 1, and
//     latency is 1 cycle.
// TESTING  (NBYTES=1, NR=2 unless noted)
//   1. Reset, then ld_i with text_in=8'hA5, w_i=8'h3C -> next cycle sa_o=8'h99,
//      round_o=0, busy_o=1.
//   2. After (1), rnd_vld_i with sa_i=8'h0F, w_i=8'hF0 -> sa_o=8'hFF, round_o=1;
//      second rnd_vld_i with sa_i=8'h12, w_i=8'h34 -> sa_o=8'h26, round_o=2,
//      done_o=1 for one cycle, busy_o=0.
//   3. In RUN, ld_i and rnd_vld_i in the same cycle (text_in=8'h01, w_i=8'h02)
//      -> sa_o=8'h03, round_o=0, no done_o.
//   4. rst asserted mid-block (round_o=1) between clock edges -> outputs are
//      immediately sa_o=0, round_o=0, busy_o=0; no done_o pulse afterwards.
//   5. rnd_vld_i in IDLE with sa_i=8'hAA -> sa_o, round_o and busy_o unchanged.
//   6. ARK_PRECHARGE_EN, repeat (1) -> cycle+1 sa_o=8'h00 and ready_o=0,
//      cycle+2 sa_o=8'h99 and ready_o=1; an rnd_vld_i during PRE is ignored.

Source files
------------

// File: rtl/aes_ark_stage.sv
// ---------------------------------------------------------------------------
// aes_ark_stage
//   AddRoundKey register stage for an iterative AES datapath. A block starts
//   with ld_i, which registers text_in ^ w_i as round 0. Each subsequent
//   round result arriving on sa_i with rnd_vld_i is registered as sa_i ^ w_i
//   and the round count advances. When the count reaches NR, done_o pulses
//   for one cycle and the stage returns to idle, holding the ciphertext.
//
//   Optional feature macro: ARK_PRECHARGE_EN
//     When defined, every accepted event goes through a one-cycle precharge
//     state. In that cycle sa_o is driven to zero, ready_o is low and the
//     XOR result is parked internally. The result appears on the following
//     cycle. When undefined, latency is one cycle and ready_o stays high.
//
// Parameters
//   NBYTES  state width in bytes (W = 8*NBYTES)
//   NR      number of round-key additions after the initial load
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   ld_i       start a block (wins over rnd_vld_i)
//   rnd_vld_i  round result valid on sa_i (ignored when idle)
//   text_in    plaintext block
//   w_i        current round key
//   sa_i       state returned from the round logic
//   sa_o       registered AddRoundKey result
//   round_o    round index of the value on sa_o (0 = initial load)
//   busy_o     block in progress
//   done_o     one-cycle pulse: sa_o holds the final ciphertext
//   ready_o    stage accepts ld_i / rnd_vld_i this cycle
// ---------------------------------------------------------------------------
module aes_ark_stage #(
    parameter  int NBYTES = 16,
    parameter  int NR     = 10,
    localparam int W      = 8 * NBYTES,
    localparam int RW     = $clog2(NR + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_i,
    input  logic          rnd_vld_i,
    input  logic [W-1:0]  text_in,
    input  logic [W-1:0]  w_i,
    input  logic [W-1:0]  sa_i,
    output logic [W-1:0]  sa_o,
    output logic [RW-1:0] round_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          ready_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
`ifdef ARK_PRECHARGE_EN
    localparam logic [1:0] ST_PRE  = 2'd2;
`endif

    localparam logic [RW-1:0] LAST_RND = RW'(NR);

    // Bytewise, carry-free key addition.
    function automatic logic [W-1:0] ark_xor(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NBYTES; i++) begin
            r[i*8 +: 8] = a[i*8 +: 8] ^ b[i*8 +: 8];
        end
        return r;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  sa_q, sa_d;
    logic [RW-1:0] round_q, round_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;

`ifdef ARK_PRECHARGE_EN
    // Result parked during the precharge cycle.
    logic [W-1:0]  op_q, op_d;
    logic [RW-1:0] op_round_q, op_round_d;
    logic          op_final_q, op_final_d;
`endif

    logic          acc_ld_s;
    logic          acc_rnd_s;
    logic [W-1:0]  res_s;
    logic [RW-1:0] res_round_s;
    logic          res_final_s;

    // Event acceptance and the value the accepted event would produce.
    always_comb begin
        acc_ld_s    = ld_i & ready_q;
        // ld_i has priority, so a coincident round result is dropped.
        acc_rnd_s   = rnd_vld_i & ~ld_i & ready_q & (state_q == ST_RUN);
        if (ld_i) begin
            res_s       = ark_xor(text_in, w_i);
            res_round_s = '0;
            res_final_s = 1'b0;
        end else begin
            res_s       = ark_xor(sa_i, w_i);
            res_round_s = round_q + RW'(1);
            res_final_s = ((round_q + RW'(1)) == LAST_RND);
        end
    end

    // Next-state logic for the FSM and all registered outputs.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        round_d = round_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ready_d = ready_q;
`ifdef ARK_PRECHARGE_EN
        op_d       = op_q;
        op_round_d = op_round_q;
        op_final_d = op_final_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (acc_ld_s || acc_rnd_s) begin
                    op_d       = res_s;
                    op_round_d = res_round_s;
                    op_final_d = res_final_s;
                    sa_d       = '0;
                    ready_d    = 1'b0;
                    state_d    = ST_PRE;
                end else begin
                    ready_d    = 1'b1;
                end
            end
            ST_PRE: begin
                sa_d    = op_q;
                round_d = op_round_q;
                busy_d  = ~op_final_q;
                done_d  = op_final_q;
                ready_d = 1'b1;
                state_d = op_final_q ? ST_IDLE : ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
`else
        ready_d = 1'b1;
        if (acc_ld_s || acc_rnd_s) begin
            sa_d    = res_s;
            round_d = res_round_s;
            busy_d  = ~res_final_s;
            done_d  = res_final_s;
            state_d = res_final_s ? ST_IDLE : ST_RUN;
        end else begin
            state_d = state_q;
        end
`endif
    end

    // State and output registers; reset aborts any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sa_q       <= '0;
            round_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
`ifdef ARK_PRECHARGE_EN
            op_q       <= '0;
            op_round_q <= '0;
            op_final_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sa_q       <= sa_d;
            round_q    <= round_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
`ifdef ARK_PRECHARGE_EN
            op_q       <= op_d;
            op_round_q <= op_round_d;
            op_final_q <= op_final_d;
`endif
        end
    end

    assign sa_o    = sa_q;
    assign round_o = round_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign ready_o = ready_q;

endmodule
